// File: rtl/result_tx_queue_if.sv
// Handshake bundle between the hash pipeline / UART byte transmitter and result_tx_queue.
// The slave modport is the queue itself; the master modport is whatever drives it.
interface result_tx_queue_if #(
    parameter int DEPTH_LOG = 2
);
    logic                 in_valid;
    logic [255:0]         in_hash;
    logic [31:0]          in_nonce;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DEPTH_LOG:0]   fifo_count;
    logic [7:0]           drop_count;
    logic                 busy;

    modport master (
        output in_valid, in_hash, in_nonce, tx_ready,
        input  tx_data, tx_valid, fifo_count, drop_count, busy
    );

    modport slave (
        input  in_valid, in_hash, in_nonce, tx_ready,
        output tx_data, tx_valid, fifo_count, drop_count, busy
    );
endinterface

// File: rtl/result_tx_queue.sv
// Filters pipeline results by difficulty, queues golden nonces in a small FIFO
// and serializes each one as a 10-byte frame towards a byte-wide UART transmitter.
module result_tx_queue #(
    parameter int          DEPTH_LOG = 2,
    parameter int          ZERO_BITS = 32,
    parameter logic [7:0]  SYNC_BYTE = 8'h55
) (
    input  logic              clk,
    input  logic              rst,
    result_tx_queue_if.slave  bus
);
    localparam int                 DEPTH   = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] DEPTH_C = (DEPTH_LOG + 1)'(DEPTH);
    // Shifting by the full width yields zero, so ZERO_BITS=256 gives an all-ones mask
    // and ZERO_BITS=0 gives an empty mask (every valid input is a hit).
    localparam logic [255:0]       HIT_MASK = ~({256{1'b1}} >> ZERO_BITS);

    typedef enum logic {IDLE, SEND} state_t;

    logic [63:0]          mem_q [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG:0]   count_q, count_d;
    logic [7:0]           drop_q, drop_d;

    state_t               state_q;
    logic [3:0]           idx_q;
    logic [63:0]          frame_q;
    logic                 tx_valid_q;
    logic [7:0]           tx_data_q;

    logic                 hit;
    logic                 push;
    logic                 pop;

    function automatic logic [7:0] frame_byte(input logic [63:0] e, input logic [3:0] i);
        logic [7:0] sum;
        sum = 8'h00;
        for (int k = 0; k < 8; k++) begin
            sum = sum ^ e[8*k +: 8];
        end
        if (i == 4'd0) begin
            return SYNC_BYTE;
        end else if (i >= 4'd9) begin
            return sum;
        end else begin
            return e[8*(int'(i) - 1) +: 8];
        end
    endfunction

    // Fullness is judged on the registered count, so a pop in the same cycle cannot save a hit.
    always_comb begin
        hit      = bus.in_valid && ((bus.in_hash & HIT_MASK) == '0);
        push     = hit && (count_q != DEPTH_C);
        pop      = (state_q == IDLE) && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (DEPTH_LOG + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (DEPTH_LOG + 1)'(1);
        end
        if (hit && !push && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {bus.in_hash[255:224], bus.in_nonce};
            end
        end
    end

    // Frame sender: the next byte is loaded into tx_data on each accepted byte,
    // so tx_data never changes while a byte is waiting for tx_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            frame_q    <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        frame_q    <= mem_q[rd_ptr_q];
                        idx_q      <= '0;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= SYNC_BYTE;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_valid_q && bus.tx_ready) begin
                        if (idx_q == 4'd9) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            idx_q     <= idx_q + 4'd1;
                            tx_data_q <= frame_byte(frame_q, idx_q + 4'd1);
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    tx_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_valid   = tx_valid_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.fifo_count = count_q;
    assign bus.drop_count = drop_q;
    assign bus.busy       = (state_q == SEND) || (count_q != '0);
endmodule

// File: tb/tb_result_tx_queue.sv
// Randomized scoreboard bench for result_tx_queue: a frame-level model predicts queue
// occupancy, drops and the byte stream; a negedge monitor compares the DUT against it.
module tb_result_tx_queue;
    localparam int DEPTH_LOG = 2;
    localparam int DEPTH     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    result_tx_queue_if #(.DEPTH_LOG(DEPTH_LOG)) bus ();

    result_tx_queue #(
        .DEPTH_LOG (DEPTH_LOG),
        .ZERO_BITS (32),
        .SYNC_BYTE (8'h55)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    logic [63:0] m_fifo [$];
    logic [7:0]  sb [$];
    bit          m_sending = 1'b0;
    int          m_idx     = 0;
    int          m_drop    = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A frame is the sync byte, nonce LSB first, hash word LSB first, then an XOR checksum.
    function automatic void model_frame(input logic [63:0] e);
        logic [31:0] nonce;
        logic [31:0] hword;
        logic [7:0]  b;
        logic [7:0]  csum;
        nonce = e[31:0];
        hword = e[63:32];
        csum  = 8'h00;
        sb.push_back(8'h55);
        for (int k = 0; k < 4; k++) begin
            b = 8'((nonce >> (8 * k)) & 32'hFF);
            csum ^= b;
            sb.push_back(b);
        end
        for (int k = 0; k < 4; k++) begin
            b = 8'((hword >> (8 * k)) & 32'hFF);
            csum ^= b;
            sb.push_back(b);
        end
        sb.push_back(csum);
    endfunction

    always @(posedge clk) begin
        int          sz;
        bit          start;
        logic [63:0] e;
        if (rst) begin
            m_fifo.delete();
            sb.delete();
            m_sending = 1'b0;
            m_idx     = 0;
            m_drop    = 0;
        end else begin
            sz    = m_fifo.size();
            start = !m_sending && (sz != 0);
            if (m_sending && bus.tx_ready) begin
                if (m_idx == 9) m_sending = 1'b0;
                else m_idx++;
            end
            if (bus.in_valid && (bus.in_hash[255:224] == 32'h0)) begin
                if (sz < DEPTH) m_fifo.push_back({bus.in_hash[255:224], bus.in_nonce});
                else if (m_drop < 255) m_drop++;
            end
            if (start) begin
                e = m_fifo.pop_front();
                m_sending = 1'b1;
                m_idx     = 0;
                model_frame(e);
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("tx_valid", 32'(bus.tx_valid), 32'(m_sending));
            checkOutput("fifo_count", 32'(bus.fifo_count), 32'(m_fifo.size()));
            checkOutput("drop_count", 32'(bus.drop_count), 32'(m_drop));
            checkOutput("busy", 32'(bus.busy), 32'(m_sending || (m_fifo.size() != 0)));
            if (bus.tx_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("tx_data_unexpected", 32'(bus.tx_data), 32'hFFFF_FFFF);
                end else begin
                    checkOutput("tx_data", 32'(bus.tx_data), 32'(sb[0]));
                    if (bus.tx_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic applyStimulus(input bit v, input logic [31:0] top, input logic [31:0] nonce, input bit ready);
        bus.in_valid = v;
        bus.in_hash  = {top, $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        bus.in_nonce = nonce;
        bus.tx_ready = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit ready);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h0, ready);
    endtask

    task automatic wait_for_idx(input int target);
        int n;
        n = 0;
        while (!(m_sending && m_idx == target) && n < 200) begin
            applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
            n++;
        end
        if (n >= 200) checkOutput("wait_idx_timeout", 32'(n), 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_sending || m_fifo.size() != 0 || sb.size() != 0) && n < 2000) begin
            applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
            n++;
        end
        if (n >= 2000) checkOutput("drain_timeout", 32'(n), 32'd0);
        idle(3, 1'b1);
    endtask

    logic [7:0] exp_single [10] = '{8'h55, 8'h78, 8'h56, 8'h34, 8'h12,
                                    8'h00, 8'h00, 8'h00, 8'h00, 8'h08};

    initial begin
        bus.in_valid = 1'b0;
        bus.in_hash  = '0;
        bus.in_nonce = '0;
        bus.tx_ready = 1'b1;
        #1;
        $display("[TB] reset");
        rst = 1'b1;
        idle(2, 1'b1);
        rst = 1'b0;
        check_en = 1'b1;
        checkOutput("reset_tx_valid", 32'(bus.tx_valid), 32'd0);
        checkOutput("reset_tx_data", 32'(bus.tx_data), 32'd0);
        checkOutput("reset_fifo_count", 32'(bus.fifo_count), 32'd0);
        checkOutput("reset_drop_count", 32'(bus.drop_count), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        idle(2, 1'b1);

        $display("[TB] single hit");
        applyStimulus(1'b1, 32'h0, 32'h1234_5678, 1'b1);
        checkOutput("lat_t1_valid", 32'(bus.tx_valid), 32'd0);
        idle(1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            checkOutput("single_valid", 32'(bus.tx_valid), 32'd1);
            checkOutput("single_byte", 32'(bus.tx_data), 32'(exp_single[i]));
            idle(1, 1'b1);
        end
        checkOutput("single_end_valid", 32'(bus.tx_valid), 32'd0);
        drain();

        $display("[TB] non-hit");
        applyStimulus(1'b1, 32'h0000_0001, 32'hCAFE_0001, 1'b1);
        idle(4, 1'b1);
        checkOutput("nonhit_fifo_count", 32'(bus.fifo_count), 32'd0);
        checkOutput("nonhit_tx_valid", 32'(bus.tx_valid), 32'd0);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 32'h0, 32'h1234_5678, 1'b1);
        wait_for_idx(3);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0);
            checkOutput("bp_valid", 32'(bus.tx_valid), 32'd1);
            checkOutput("bp_byte", 32'(bus.tx_data), 32'h34);
        end
        drain();

        $display("[TB] overflow");
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'h0, 32'(32'hA000_0000 + i), 1'b0);
        idle(2, 1'b0);
        checkOutput("ovf_fifo_count", 32'(bus.fifo_count), 32'd4);
        checkOutput("ovf_drop_count", 32'(bus.drop_count), 32'd1);
        drain();

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h0, 32'(32'hB000_0000 + i), 1'b1);
        wait_for_idx(5);
        rst = 1'b1;
        idle(1, 1'b1);
        rst = 1'b0;
        checkOutput("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
        checkOutput("midrst_fifo_count", 32'(bus.fifo_count), 32'd0);
        idle(20, 1'b1);
        checkOutput("midrst_quiet", 32'(bus.tx_valid), 32'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 2) == 0,
                          ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom(),
                          $urandom(),
                          $urandom_range(0, 3) != 0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
